instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter DEPTH, 32, number of 10-bit program memory words.
REQ-002 Parameter AW, 5, program memory address width (DEPTH = 2**AW).
REQ-003 The module SHALL have one clock and a synchronous, active-high reset, with ports CLKb and CLR.
REQ-004 CLKb  input  1  debounced processor clock; all state updates on rising edge.
REQ-005 CLR  input  1  synchronous active-high reset.
REQ-006 wr_en  input  1  program memory write strobe; honoured only in IDLE.
REQ-007 wr_addr  input  AW  program memory write address.
REQ-008 wr_data  input  10  program memory write data.
REQ-009 prog_len  input  AW+1  number of valid words (0..DEPTH); sampled on start.
REQ-010 run  input  1  start pulse from IDLE/HALT; resume pulse from PAUSE.
REQ-011 step_mode  input  1  1 = pause after every completed instruction.
REQ-012 ir_en  input  1  controller IRin; current D_out consumed as instruction this cycle.
REQ-013 ext_en  input  1  controller Ext; current D_out consumed as immediate this cycle.
REQ-014 done  input  1  controller end-of-instruction indication.
REQ-015 D_out  output  10  word presented to the data bus D input.
REQ-016 d_valid  output  1  D_out holds a program word.
REQ-017 pc  output  AW+1  next program word index.
REQ-018 instr_cnt  output  8  instructions issued, saturating at 255.
REQ-019 halted  output  1  state is HALT.
REQ-020 error  output  1  sticky: consumption attempted with pc >= prog_len.

Function
REQ-021 The block SHALL hold a DEPTH x 10 memory, written on the CLKb edge when wr_en=1 and state=IDLE; writes in other states SHALL be ignored.
REQ-022 States SHALL be IDLE, FETCH, EXEC, PAUSE, HALT.
REQ-023 IDLE/HALT + run=1: latch prog_len, pc<=0, error<=0; go FETCH if latched length >0, else HALT.
REQ-024 FETCH: D_out=mem[pc], d_valid=1; on ir_en=1 -> pc<=pc+1, instr_cnt+=1 (saturating), go EXEC.
REQ-025 EXEC: D_out=mem[pc], d_valid=1 when pc<len, else D_out=0, d_valid=0; on ext_en=1 with pc<len -> pc<=pc+1.
REQ-026 EXEC + done=1: pc>=len -> HALT; else step_mode=1 -> PAUSE; else FETCH.
REQ-027 ext_en and done in the same EXEC cycle: the immediate SHALL be consumed (pc advances) before the done transition is evaluated against the updated pc.
REQ-028 PAUSE: D_out=0, d_valid=0; run=1 -> FETCH; ir_en/ext_en ignored.
REQ-029 ir_en or ext_en with pc>=len, in FETCH or EXEC: set error=1, pc unchanged, go HALT.
REQ-030 ir_en outside FETCH, or ext_en outside EXEC, SHALL be ignored; no pc change.
REQ-031 D_out SHALL be combinational from registered pc and state (zero added latency); in IDLE and HALT D_out=0, d_valid=0.
REQ-032 pc SHALL never exceed the latched length; no wrap-around.
REQ-033 run held high for multiple cycles SHALL act as one pulse (rising-edge detected internally).

Reset
REQ-034 CLR=1 SHALL force state=IDLE, pc=0, instr_cnt=0, error=0, D_out=0, d_valid=0, halted=0, from any state including mid-instruction.
REQ-035 CLR SHALL NOT clear program memory contents.
REQ-036 CLR has priority over run, wr_en, ir_en, ext_en and done in the same cycle.

Verification
REQ-037 Load mem[0]=10'h041, mem[1]=10'h123, prog_len=2; run; ir_en in FETCH -> D_out=10'h041 before, pc=1 after; ext_en in EXEC -> D_out=10'h123 consumed, pc=2; done -> HALT, instr_cnt=1, error=0.
REQ-038 prog_len=3, step_mode=1, three one-word instructions each ending with done -> PAUSE after first and second, D_out=0 in PAUSE; run resumes; HALT after third, instr_cnt=3.
REQ-039 prog_len=1, ir_en then ext_en -> error=1, HALT, pc=1, D_out=0.
REQ-040 ext_en and done same cycle with pc=1, prog_len=3 -> pc=2, next state FETCH, D_out=mem[2].
REQ-041 CLR asserted in EXEC with pc=5 -> next cycle IDLE, pc=0, instr_cnt=0; memory words unchanged on readback after rerun.
REQ-042 prog_len=0 run -> HALT immediately, d_valid never asserted; wr_en during EXEC -> memory word unchanged.

Source files
------------

// File: rtl/instr_sequencer.sv
// Program-word sequencer: holds a small program memory and presents words on D_out
// as the controller consumes instructions (ir_en) and immediates (ext_en).
module instr_sequencer #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic          CLKb,
    input  logic          CLR,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [9:0]    wr_data,
    input  logic [AW:0]   prog_len,
    input  logic          run,
    input  logic          step_mode,
    input  logic          ir_en,
    input  logic          ext_en,
    input  logic          done,
    output logic [9:0]    D_out,
    output logic          d_valid,
    output logic [AW:0]   pc,
    output logic [7:0]    instr_cnt,
    output logic          halted,
    output logic          error
);

    typedef enum logic [2:0] {StIdle, StFetch, StExec, StPause, StHalt} state_e;

    logic [9:0]  mem [DEPTH];
    state_e      state_q, state_d;
    logic [AW:0] pc_q, pc_d, len_q, len_d, pc_adv;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d, run_q, run_rise, in_range;
    logic [9:0]  rd_word;

    assign run_rise = run & ~run_q;
    assign in_range = (pc_q < len_q);
    assign rd_word  = mem[pc_q[AW-1:0]];

    // Memory is not reset so the program survives CLR.
    always_ff @(posedge CLKb) begin
        if (!CLR && wr_en && (state_q == StIdle)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge CLKb) begin
        if (CLR) begin
            state_q <= StIdle;
            pc_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            run_q   <= run;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        pc_adv  = pc_q;
        D_out   = '0;
        d_valid = 1'b0;
        unique case (state_q)
            StIdle, StHalt: begin
                if (run_rise) begin
                    len_d   = prog_len;
                    pc_d    = '0;
                    err_d   = 1'b0;
                    state_d = (prog_len != '0) ? StFetch : StHalt;
                end
            end
            StFetch: begin
                if (in_range) begin
                    D_out   = rd_word;
                    d_valid = 1'b1;
                end
                if (ir_en) begin
                    if (in_range) begin
                        pc_d    = pc_q + 1'b1;
                        cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                        state_d = StExec;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StHalt;
                    end
                end
            end
            StExec: begin
                if (in_range) begin
                    D_out   = rd_word;
                    d_valid = 1'b1;
                end
                if (ext_en && !in_range) begin
                    err_d   = 1'b1;
                    state_d = StHalt;
                end else begin
                    // Immediate is consumed first; done then sees the advanced pc.
                    if (ext_en) begin
                        pc_adv = pc_q + 1'b1;
                    end
                    pc_d = pc_adv;
                    if (done) begin
                        if (pc_adv >= len_q) begin
                            state_d = StHalt;
                        end else if (step_mode) begin
                            state_d = StPause;
                        end else begin
                            state_d = StFetch;
                        end
                    end
                end
            end
            StPause: begin
                if (run_rise) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign pc        = pc_q;
    assign instr_cnt = cnt_q;
    assign halted    = (state_q == StHalt);
    assign error     = err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer.
module tb_instr_sequencer;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;

    logic          CLKb = 1'b0;
    logic          CLR, wr_en, run, step_mode, ir_en, ext_en, done;
    logic [AW-1:0] wr_addr;
    logic [9:0]    wr_data;
    logic [AW:0]   prog_len;
    logic [9:0]    D_out;
    logic          d_valid, halted, error;
    logic [AW:0]   pc;
    logic [7:0]    instr_cnt;

    int checks = 0;
    int errors = 0;

    instr_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLKb      (CLKb),
        .CLR       (CLR),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .prog_len  (prog_len),
        .run       (run),
        .step_mode (step_mode),
        .ir_en     (ir_en),
        .ext_en    (ext_en),
        .done      (done),
        .D_out     (D_out),
        .d_valid   (d_valid),
        .pc        (pc),
        .instr_cnt (instr_cnt),
        .halted    (halted),
        .error     (error)
    );

    always #5 CLKb = ~CLKb;

    task automatic tick();
        @(posedge CLKb);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [9:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
    endtask

    task automatic pulse(input int which);
        if (which == 0) ir_en = 1'b1;
        if (which == 1) ext_en = 1'b1;
        if (which == 2) done = 1'b1;
        tick();
        ir_en  = 1'b0;
        ext_en = 1'b0;
        done   = 1'b0;
    endtask

    initial begin
        CLR = 1'b1; wr_en = 1'b0; run = 1'b0; step_mode = 1'b0;
        ir_en = 1'b0; ext_en = 1'b0; done = 1'b0;
        wr_addr = '0; wr_data = '0; prog_len = '0;
        tick();
        tick();
        CLR = 1'b0;

        chk("rst_pc", pc, 0);
        chk("rst_cnt", instr_cnt, 0);
        chk("rst_err", error, 0);
        chk("rst_dvalid", d_valid, 0);
        chk("rst_dout", D_out, 0);
        chk("rst_halted", halted, 0);

        write_word(5'd0, 10'h041);
        write_word(5'd1, 10'h123);
        write_word(5'd2, 10'h2AA);
        write_word(5'd3, 10'h155);
        write_word(5'd4, 10'h3C3);
        write_word(5'd5, 10'h0F0);
        write_word(5'd6, 10'h1E1);

        // Basic instruction with immediate
        prog_len = 6'd2;
        pulse_run();
        chk("s1_fetch_dout", D_out, 10'h041);
        chk("s1_fetch_valid", d_valid, 1);
        chk("s1_fetch_pc", pc, 0);
        pulse(0);
        chk("s1_exec_pc", pc, 1);
        chk("s1_exec_dout", D_out, 10'h123);
        chk("s1_cnt", instr_cnt, 1);
        pulse(1);
        chk("s1_imm_pc", pc, 2);
        chk("s1_end_valid", d_valid, 0);
        chk("s1_end_dout", D_out, 0);
        pulse(2);
        chk("s1_halted", halted, 1);
        chk("s1_cnt_final", instr_cnt, 1);
        chk("s1_err", error, 0);
        chk("s1_halt_valid", d_valid, 0);

        // Step mode
        do_reset();
        step_mode = 1'b1;
        prog_len  = 6'd3;
        pulse_run();
        chk("s2_f0_dout", D_out, 10'h041);
        pulse(0);
        pulse(2);
        chk("s2_p1_dout", D_out, 0);
        chk("s2_p1_valid", d_valid, 0);
        chk("s2_p1_halted", halted, 0);
        pulse(0);
        pulse(1);
        chk("s2_p1_ignore_pc", pc, 1);
        chk("s2_p1_ignore_cnt", instr_cnt, 1);
        // Resume with run held high across the next pause
        run = 1'b1;
        tick();
        chk("s2_f1_dout", D_out, 10'h123);
        pulse(0);
        pulse(2);
        tick();
        chk("s2_hold_pause", d_valid, 0);
        chk("s2_hold_pc", pc, 2);
        run = 1'b0;
        tick();
        pulse_run();
        chk("s2_f2_dout", D_out, 10'h2AA);
        pulse(0);
        chk("s2_e2_valid", d_valid, 0);
        pulse(2);
        chk("s2_halted", halted, 1);
        chk("s2_cnt", instr_cnt, 3);
        step_mode = 1'b0;

        // Immediate past end of program
        do_reset();
        prog_len = 6'd1;
        pulse_run();
        pulse(0);
        pulse(1);
        chk("s3_err", error, 1);
        chk("s3_halted", halted, 1);
        chk("s3_pc", pc, 1);
        chk("s3_dout", D_out, 0);

        // ext_en and done together
        do_reset();
        prog_len = 6'd3;
        pulse_run();
        pulse(0);
        chk("s4_exec_dout", D_out, 10'h123);
        ext_en = 1'b1;
        done   = 1'b1;
        tick();
        ext_en = 1'b0;
        done   = 1'b0;
        chk("s4_pc", pc, 2);
        chk("s4_fetch_dout", D_out, 10'h2AA);
        chk("s4_fetch_valid", d_valid, 1);
        chk("s4_not_halted", halted, 0);
        pulse(1);
        chk("s4_ext_in_fetch_pc", pc, 2);

        // CLR mid-instruction
        do_reset();
        prog_len = 6'd7;
        pulse_run();
        pulse(0);
        for (int i = 0; i < 4; i++) pulse(1);
        chk("s5_pc5", pc, 5);
        chk("s5_dout5", D_out, 10'h0F0);
        CLR = 1'b1; ext_en = 1'b1; done = 1'b1; run = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 10'h3FF;
        tick();
        CLR = 1'b0; ext_en = 1'b0; done = 1'b0; run = 1'b0; wr_en = 1'b0;
        chk("s5_clr_pc", pc, 0);
        chk("s5_clr_cnt", instr_cnt, 0);
        chk("s5_clr_valid", d_valid, 0);
        chk("s5_clr_halted", halted, 0);
        tick();
        pulse_run();
        chk("s5_rb0", D_out, 10'h041);
        pulse(0);
        chk("s5_rb1", D_out, 10'h123);
        pulse(1);
        chk("s5_rb2", D_out, 10'h2AA);
        pulse(1);
        chk("s5_rb3", D_out, 10'h155);

        // Empty program, writes outside IDLE
        do_reset();
        prog_len = 6'd0;
        run = 1'b1;
        tick();
        chk("s6_len0_halted", halted, 1);
        chk("s6_len0_valid", d_valid, 0);
        run = 1'b0;
        write_word(5'd2, 10'h000);
        chk("s6_halt_valid", d_valid, 0);
        do_reset();
        prog_len = 6'd3;
        pulse_run();
        pulse(0);
        write_word(5'd1, 10'h3FF);
        chk("s6_exec_word", D_out, 10'h123);
        pulse(1);
        chk("s6_halt_word", D_out, 10'h2AA);

        // Counter saturation and no pc wrap on a full-length program
        do_reset();
        prog_len = 6'd32;
        for (int r = 0; r < 9; r++) begin
            pulse_run();
            for (int k = 0; k < 32; k++) begin
                pulse(0);
                pulse(2);
            end
        end
        chk("s7_cnt_sat", instr_cnt, 8'hFF);
        chk("s7_halted", halted, 1);
        chk("s7_pc_full", pc, 32);
        chk("s7_err", error, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
